// File: rtl/mux_pipe_n.sv
// N:1 datapath select feeding a two-entry skid-buffered output register stage.
// Optional MUX_HOLD_LAST_EN: out-of-range selects return the last in-range word instead of zero.
module mux_pipe_n #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // One extra bit so NUM_IN == 2**SEL_W is still representable.
    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_mainData;
    logic [SEL_W-1:0]   r_mainSel;
    logic               r_mainErr;
    logic [WIDTH-1:0]   r_skidData;
    logic [SEL_W-1:0]   r_skidSel;
    logic               r_skidErr;

    logic               w_accept;
    logic               w_drain;
    logic               w_inRange;
    logic [WIDTH-1:0]   w_selData;
    logic [WIDTH-1:0]   w_newData;
    logic               w_loadMainNew;
    logic               w_loadMainSkid;
    logic               w_loadSkid;

    assign in_ready  = (r_state != FULL);
    assign out_valid = (r_state != EMPTY);
    assign out_data  = r_mainData;
    assign out_sel   = r_mainSel;
    assign out_err   = r_mainErr;

    assign w_accept  = in_valid & in_ready;
    assign w_drain   = out_valid & out_ready;
    assign w_inRange = ({1'b0, in_sel} < NUM_IN_W);

    always_comb begin
        w_selData = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                w_selData = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef MUX_HOLD_LAST_EN
    logic [WIDTH-1:0] r_holdLast;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_holdLast <= '0;
        end else if (w_accept && w_inRange) begin
            r_holdLast <= w_selData;
        end
    end

    assign w_newData = w_inRange ? w_selData : r_holdLast;
`else
    assign w_newData = w_inRange ? w_selData : '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        w_loadMainNew  = 1'b0;
        w_loadMainSkid = 1'b0;
        w_loadSkid     = 1'b0;
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_next        = ONE;
                    w_loadMainNew = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_drain) begin
                    w_loadMainNew = 1'b1;
                end else if (w_accept) begin
                    w_next     = FULL;
                    w_loadSkid = 1'b1;
                end else if (w_drain) begin
                    w_next = EMPTY;
                end
            end
            FULL: begin
                if (w_drain) begin
                    w_next         = ONE;
                    w_loadMainSkid = 1'b1;
                end
            end
            default: w_next = EMPTY;
        endcase
    end

    // Main always presents the oldest word; skid only ever holds the one behind it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mainData <= '0;
            r_mainSel  <= '0;
            r_mainErr  <= 1'b0;
            r_skidData <= '0;
            r_skidSel  <= '0;
            r_skidErr  <= 1'b0;
        end else begin
            if (w_loadMainNew) begin
                r_mainData <= w_newData;
                r_mainSel  <= in_sel;
                r_mainErr  <= ~w_inRange;
            end else if (w_loadMainSkid) begin
                r_mainData <= r_skidData;
                r_mainSel  <= r_skidSel;
                r_mainErr  <= r_skidErr;
            end
            if (w_loadSkid) begin
                r_skidData <= w_newData;
                r_skidSel  <= in_sel;
                r_skidErr  <= ~w_inRange;
            end
        end
    end

endmodule

// File: tb/tb_mux_pipe_n.sv
// Scoreboard bench for mux_pipe_n: three instances (32b/4-in, 32b/3-in, 8b/8-in).
// Expected out-of-range data follows MUX_HOLD_LAST_EN when defined.
module tb_mux_pipe_n;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  sel;
        logic        err;
    } exp_t;

`ifdef MUX_HOLD_LAST_EN
    localparam logic [31:0] HOLD_B = 32'h22222222;
`else
    localparam logic [31:0] HOLD_B = 32'h00000000;
`endif

    logic clk;
    logic rst;

    logic [127:0] aInData;
    logic [1:0]   aInSel;
    logic         aInValid, aInReady;
    logic [31:0]  aOutData;
    logic [1:0]   aOutSel;
    logic         aOutErr, aOutValid, aOutReady;

    logic [95:0]  bInData;
    logic [1:0]   bInSel;
    logic         bInValid, bInReady;
    logic [31:0]  bOutData;
    logic [1:0]   bOutSel;
    logic         bOutErr, bOutValid, bOutReady;

    logic [63:0]  cInData;
    logic [2:0]   cInSel;
    logic         cInValid, cInReady;
    logic [7:0]   cOutData;
    logic [2:0]   cOutSel;
    logic         cOutErr, cOutValid, cOutReady;

    exp_t qA[$];
    exp_t qB[$];
    exp_t qC[$];
    exp_t popA, popB, popC;
    int   assertions = 0;
    int   failures   = 0;

    logic [31:0] wordsA [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

    mux_pipe_n #(.WIDTH(32), .NUM_IN(4), .SEL_W(2)) dutA (
        .clk(clk), .rst(rst), .in_data(aInData), .in_sel(aInSel), .in_valid(aInValid),
        .in_ready(aInReady), .out_data(aOutData), .out_sel(aOutSel), .out_err(aOutErr),
        .out_valid(aOutValid), .out_ready(aOutReady)
    );

    mux_pipe_n #(.WIDTH(32), .NUM_IN(3), .SEL_W(2)) dutB (
        .clk(clk), .rst(rst), .in_data(bInData), .in_sel(bInSel), .in_valid(bInValid),
        .in_ready(bInReady), .out_data(bOutData), .out_sel(bOutSel), .out_err(bOutErr),
        .out_valid(bOutValid), .out_ready(bOutReady)
    );

    mux_pipe_n #(.WIDTH(8), .NUM_IN(8), .SEL_W(3)) dutC (
        .clk(clk), .rst(rst), .in_data(cInData), .in_sel(cInSel), .in_valid(cInValid),
        .in_ready(cInReady), .out_data(cOutData), .out_sel(cOutSel), .out_err(cOutErr),
        .out_valid(cOutValid), .out_ready(cOutReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic noteUnexpected(input string name, input logic [31:0] actual);
        assertions++;
        failures++;
        $display("[TB] FAIL %s: unexpected output data=%0h with empty scoreboard", name, actual);
    endtask

    // Monitors compare at the falling edge, where a word with valid & ready is about to drain.
    always @(negedge clk) begin
        if (!rst && aOutValid && aOutReady) begin
            if (qA.size() == 0) noteUnexpected("monA", aOutData);
            else begin
                popA = qA.pop_front();
                checkOutput("monA data", aOutData, popA.data);
                checkOutput("monA sel", 32'(aOutSel), 32'(popA.sel));
                checkOutput("monA err", 32'(aOutErr), 32'(popA.err));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bOutValid && bOutReady) begin
            if (qB.size() == 0) noteUnexpected("monB", bOutData);
            else begin
                popB = qB.pop_front();
                checkOutput("monB data", bOutData, popB.data);
                checkOutput("monB sel", 32'(bOutSel), 32'(popB.sel));
                checkOutput("monB err", 32'(bOutErr), 32'(popB.err));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && cOutValid && cOutReady) begin
            if (qC.size() == 0) noteUnexpected("monC", 32'(cOutData));
            else begin
                popC = qC.pop_front();
                checkOutput("monC data", 32'(cOutData), popC.data);
                checkOutput("monC sel", 32'(cOutSel), 32'(popC.sel));
                checkOutput("monC err", 32'(cOutErr), 32'(popC.err));
            end
        end
    end

    // Send tasks are entered just after a rising edge and return just after the accepting edge.
    task automatic sendA(input logic [1:0] sel, input logic [31:0] expData, input logic expErr, output int cycles);
        logic rdy;
        exp_t e;
        aInValid = 1'b1;
        aInSel   = sel;
        cycles   = 0;
        do begin
            rdy = aInReady;
            @(posedge clk);
            #1;
            cycles++;
        end while (!rdy && cycles < 20);
        if (!rdy) noteUnexpected("sendA timeout", 32'(sel));
        else begin
            e.data = expData; e.sel = {1'b0, sel}; e.err = expErr;
            qA.push_back(e);
        end
    endtask

    task automatic sendB(input logic [1:0] sel, input logic [31:0] expData, input logic expErr);
        logic rdy;
        int   cycles;
        exp_t e;
        bInValid = 1'b1;
        bInSel   = sel;
        cycles   = 0;
        do begin
            rdy = bInReady;
            @(posedge clk);
            #1;
            cycles++;
        end while (!rdy && cycles < 20);
        if (!rdy) noteUnexpected("sendB timeout", 32'(sel));
        else begin
            e.data = expData; e.sel = {1'b0, sel}; e.err = expErr;
            qB.push_back(e);
        end
    endtask

    task automatic sendC(input logic [2:0] sel, input logic [7:0] expData, input logic expErr);
        logic rdy;
        int   cycles;
        exp_t e;
        cInValid = 1'b1;
        cInSel   = sel;
        cycles   = 0;
        do begin
            rdy = cInReady;
            @(posedge clk);
            #1;
            cycles++;
        end while (!rdy && cycles < 20);
        if (!rdy) noteUnexpected("sendC timeout", 32'(sel));
        else begin
            e.data = 32'(expData); e.sel = sel; e.err = expErr;
            qC.push_back(e);
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((qA.size() != 0 || qB.size() != 0 || qC.size() != 0) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drainA", 32'(qA.size()), 32'd0);
        checkOutput("drainB", 32'(qB.size()), 32'd0);
        checkOutput("drainC", 32'(qC.size()), 32'd0);
    endtask

    task automatic applyStimulus();
        int cyc;

        // Reset with words presented on every instance; none of them may come out.
        rst = 1'b1;
        aInValid = 1'b1; aInSel = 2'd1;
        bInValid = 1'b1; bInSel = 2'd0;
        cInValid = 1'b1; cInSel = 3'd7;
        @(posedge clk); #1;
        checkOutput("inReadyDuringReset", 32'(aInReady), 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        aInValid = 1'b0; bInValid = 1'b0; cInValid = 1'b0;
        checkOutput("rstOutValid", 32'(aOutValid), 32'd0);
        checkOutput("rstOutData", aOutData, 32'd0);
        checkOutput("rstOutSel", 32'(aOutSel), 32'd0);
        checkOutput("rstOutErr", 32'(aOutErr), 32'd0);
        checkOutput("rstInReady", 32'(aInReady), 32'd1);
        checkOutput("rstOutValidB", 32'(bOutValid), 32'd0);
        checkOutput("rstOutValidC", 32'(cOutValid), 32'd0);

        // Single word, one-cycle latency, then empty again.
        sendA(2'd2, 32'h33333333, 1'b0, cyc);
        aInValid = 1'b0;
        checkOutput("basicValid", 32'(aOutValid), 32'd1);
        checkOutput("basicData", aOutData, 32'h33333333);
        checkOutput("basicSel", 32'(aOutSel), 32'd2);
        checkOutput("basicErr", 32'(aOutErr), 32'd0);
        @(posedge clk); #1;
        checkOutput("basicValidAfter", 32'(aOutValid), 32'd0);

        // Backpressure fills both entries; the third word waits for ready.
        aOutReady = 1'b0;
        sendA(2'd0, 32'h11111111, 1'b0, cyc);
        sendA(2'd1, 32'h22222222, 1'b0, cyc);
        aInSel = 2'd2;
        checkOutput("fullInReady", 32'(aInReady), 32'd0);
        checkOutput("fullHeldData", aOutData, 32'h11111111);
        @(posedge clk); #1;
        checkOutput("fullInReady2", 32'(aInReady), 32'd0);
        checkOutput("fullHeldData2", aOutData, 32'h11111111);
        checkOutput("fullHeldValid", 32'(aOutValid), 32'd1);
        aOutReady = 1'b1;
        sendA(2'd2, 32'h33333333, 1'b0, cyc);
        aInValid = 1'b0;
        waitDrain();

        // Streaming: one word per cycle with in_ready held high.
        for (int i = 0; i < 8; i++) begin
            sendA(2'(i % 4), wordsA[i % 4], 1'b0, cyc);
            checkOutput("streamAcceptCycles", 32'(cyc), 32'd1);
            checkOutput("streamLatencySel", 32'(aOutSel), 32'(i % 4));
        end
        aInValid = 1'b0;
        waitDrain();

        // Out-of-range selects on the 3-input instance.
        sendB(2'd3, 32'h00000000, 1'b1);
        sendB(2'd1, 32'h22222222, 1'b0);
        sendB(2'd3, HOLD_B, 1'b1);
        checkOutput("oorData", bOutData, HOLD_B);
        checkOutput("oorErr", 32'(bOutErr), 32'd1);
        checkOutput("oorSel", 32'(bOutSel), 32'd3);
        sendB(2'd0, 32'h11111111, 1'b0);
        bInValid = 1'b0;

        // Top select code on the 8-input, 8-bit instance.
        sendC(3'd7, 8'hA5, 1'b0);
        checkOutput("c7Data", 32'(cOutData), 32'h000000A5);
        checkOutput("c7Sel", 32'(cOutSel), 32'd7);
        sendC(3'd0, 8'h10, 1'b0);
        cInValid = 1'b0;
        waitDrain();

        // Reset while FULL discards both entries and the word offered during reset.
        aOutReady = 1'b0;
        sendA(2'd1, 32'h22222222, 1'b0, cyc);
        sendA(2'd3, 32'h44444444, 1'b0, cyc);
        checkOutput("preResetFull", 32'(aInReady), 32'd0);
        rst = 1'b1;
        aInSel = 2'd0;
        @(posedge clk); #1;
        rst = 1'b0;
        aInValid = 1'b0;
        qA.delete();
        checkOutput("midRstValid", 32'(aOutValid), 32'd0);
        checkOutput("midRstData", aOutData, 32'd0);
        checkOutput("midRstInReady", 32'(aInReady), 32'd1);
        aOutReady = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("midRstStaysEmpty", 32'(aOutValid), 32'd0);
    endtask

    initial begin
        aInData = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
        bInData = {32'h33333333, 32'h22222222, 32'h11111111};
        cInData = {8'hA5, 8'h16, 8'h15, 8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
        aInSel = '0; bInSel = '0; cInSel = '0;
        aInValid = 1'b0; bInValid = 1'b0; cInValid = 1'b0;
        aOutReady = 1'b1; bOutReady = 1'b1; cOutReady = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        applyStimulus();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
